// File: rtl/alu_arbiter.sv
// alu_arbiter: two-client round-robin arbiter/sequencer in front of one shared combinational ALU.
// Latency: request accepted at edge N, rsp_valid high from cycle N+2; minimum 3 cycles per transaction.
// Backpressure: req_ready only in IDLE; the response holds in RESP until the granted client's rsp_ready.
//
// Ports:
//   clk_i, rst_i                 clock, synchronous active-high reset
//   req_valid_i/req_ready_o[1:0] per-client request handshake (bit i = client i)
//   req_a0_i/req_b0_i/req_op0_i  client 0 operands and opcode
//   req_a1_i/req_b1_i/req_op1_i  client 1 operands and opcode
//   rsp_valid_o/rsp_ready_i[1:0] per-client response handshake
//   rsp_data_o, rsp_err_o        registered ALU result (shared) and unsupported-opcode flag
//   alu_a_o/alu_b_o/alu_op_o     operands to the ALU, alu_out_i its combinational result
//
// Build option: ALU_ARB_FIXED_PRIO_EN -- when defined, client 0 always wins a tie and the
// round-robin pointer is removed. Handshakes and latency are identical in both builds.

module alu_arbiter #(
  parameter int WIDTH = 8,
  parameter int OPW   = 4
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic [1:0]       req_valid_i,
  output logic [1:0]       req_ready_o,
  input  logic [WIDTH-1:0] req_a0_i,
  input  logic [WIDTH-1:0] req_b0_i,
  input  logic [OPW-1:0]   req_op0_i,
  input  logic [WIDTH-1:0] req_a1_i,
  input  logic [WIDTH-1:0] req_b1_i,
  input  logic [OPW-1:0]   req_op1_i,
  output logic [1:0]       rsp_valid_o,
  input  logic [1:0]       rsp_ready_i,
  output logic [WIDTH-1:0] rsp_data_o,
  output logic             rsp_err_o,
  output logic [WIDTH-1:0] alu_a_o,
  output logic [WIDTH-1:0] alu_b_o,
  output logic [OPW-1:0]   alu_op_o,
  input  logic [WIDTH-1:0] alu_out_i
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    RESP = 2'd2
  } state_t;

  state_t           state_q, state_d;
  logic             gnt_q, gnt_d;
  logic [WIDTH-1:0] a_q, a_d;
  logic [WIDTH-1:0] b_q, b_d;
  logic [OPW-1:0]   op_q, op_d;
  logic             err_q, err_d;
  logic [WIDTH-1:0] data_q, data_d;
  logic [1:0]       rsp_valid_q, rsp_valid_d;
`ifndef ALU_ARB_FIXED_PRIO_EN
  logic             last_q, last_d;
`endif

  logic             win;
  logic [OPW-1:0]   op_sel;

  // Winner selection. A single requester always wins; only a tie consults the policy.
  always_comb begin
`ifdef ALU_ARB_FIXED_PRIO_EN
    win = ~req_valid_i[0];
`else
    if (&req_valid_i) begin
      win = ~last_q;
    end else begin
      win = req_valid_i[1];
    end
`endif
    op_sel = win ? req_op1_i : req_op0_i;
  end

  always_comb begin
    state_d     = state_q;
    gnt_d       = gnt_q;
    a_d         = a_q;
    b_d         = b_q;
    op_d        = op_q;
    err_d       = err_q;
    data_d      = data_q;
    rsp_valid_d = rsp_valid_q;
`ifndef ALU_ARB_FIXED_PRIO_EN
    last_d      = last_q;
`endif
    req_ready_o = 2'b00;

    case (state_q)
      IDLE: begin
        // Accept strobe is combinational but suppressed while reset is asserted.
        if ((|req_valid_i) && !rst_i) begin
          req_ready_o = win ? 2'b10 : 2'b01;
          gnt_d       = win;
          a_d         = win ? req_a1_i : req_a0_i;
          b_d         = win ? req_b1_i : req_b0_i;
          op_d        = op_sel;
          err_d       = (op_sel > OPW'(8));
`ifndef ALU_ARB_FIXED_PRIO_EN
          last_d      = win;
`endif
          state_d     = EXEC;
        end
      end
      EXEC: begin
        data_d      = alu_out_i;
        rsp_valid_d = gnt_q ? 2'b10 : 2'b01;
        state_d     = RESP;
      end
      RESP: begin
        // Only the granted client's rsp_ready completes the response.
        if (rsp_ready_i[gnt_q]) begin
          rsp_valid_d = 2'b00;
          state_d     = IDLE;
        end
      end
      default: begin
        rsp_valid_d = 2'b00;
        state_d     = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q     <= IDLE;
      gnt_q       <= 1'b0;
      a_q         <= '0;
      b_q         <= '0;
      op_q        <= '0;
      err_q       <= 1'b0;
      data_q      <= '0;
      rsp_valid_q <= 2'b00;
`ifndef ALU_ARB_FIXED_PRIO_EN
      last_q      <= 1'b1;
`endif
    end else begin
      state_q     <= state_d;
      gnt_q       <= gnt_d;
      a_q         <= a_d;
      b_q         <= b_d;
      op_q        <= op_d;
      err_q       <= err_d;
      data_q      <= data_d;
      rsp_valid_q <= rsp_valid_d;
`ifndef ALU_ARB_FIXED_PRIO_EN
      last_q      <= last_d;
`endif
    end
  end

  // The ALU port is driven only from the operand registers, so it never follows
  // live client inputs and holds the last accepted operands outside EXEC.
  assign alu_a_o     = a_q;
  assign alu_b_o     = b_q;
  assign alu_op_o    = op_q;
  assign rsp_data_o  = data_q;
  assign rsp_err_o   = err_q;
  assign rsp_valid_o = rsp_valid_q;

endmodule

// File: tb/tb_alu_arbiter.sv
// tb_alu_arbiter: randomized and directed stimulus for alu_arbiter, checked every cycle
// against a transaction-level reference model, plus literal expectations for key scenarios.
// Inputs change 1 time unit after the rising edge; outputs are sampled on the falling edge.

module tb_alu_arbiter;

  logic       clk = 1'b0;
  logic       rst;
  logic [1:0] req_valid, req_ready, rsp_valid, rsp_ready;
  logic [7:0] a0, b0, a1, b1;
  logic [3:0] op0, op1;
  logic [7:0] rsp_data;
  logic       rsp_err;
  logic [7:0] alu_a, alu_b, alu_out;
  logic [3:0] alu_op;

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  alu_arbiter #(.WIDTH(8), .OPW(4)) dut (
    .clk_i       (clk),
    .rst_i       (rst),
    .req_valid_i (req_valid),
    .req_ready_o (req_ready),
    .req_a0_i    (a0),
    .req_b0_i    (b0),
    .req_op0_i   (op0),
    .req_a1_i    (a1),
    .req_b1_i    (b1),
    .req_op1_i   (op1),
    .rsp_valid_o (rsp_valid),
    .rsp_ready_i (rsp_ready),
    .rsp_data_o  (rsp_data),
    .rsp_err_o   (rsp_err),
    .alu_a_o     (alu_a),
    .alu_b_o     (alu_b),
    .alu_op_o    (alu_op),
    .alu_out_i   (alu_out)
  );

  // Stand-in for the shared ALU: results reduced modulo 256, unsupported opcodes give 0.
  function automatic logic [7:0] ref_alu(input logic [7:0] a, input logic [7:0] b, input logic [3:0] op);
    int ia;
    int ib;
    int r;
    ia = int'(a);
    ib = int'(b);
    case (op)
      4'd0: r = ia + ib;
      4'd1: r = ia - ib;
      4'd2: r = ia & ib;
      4'd3: r = ia | ib;
      4'd4: r = (ib > 7) ? 0 : (ia >> ib);
      4'd5: r = (ib > 7) ? 0 : (ia << ib);
      4'd6: r = ia ^ ib;
      4'd7: r = ~ia;
      4'd8: r = (ia == ib) ? 1 : 0;
      default: r = 0;
    endcase
    return 8'(r & 255);
  endfunction

  assign alu_out = ref_alu(alu_a, alu_b, alu_op);

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- transaction-level reference model ----------------
  bit         m_ok = 1'b0;  // becomes true once a reset has been observed
  bit         m_busy;       // a transaction is in flight
  int         m_age;        // cycles since its accept edge (1 = executing, >=2 = responding)
  int         m_g;          // client being served
  int         m_last;       // most recently served client
  logic [7:0] m_a, m_b, m_data;
  logic [3:0] m_op;
  logic       m_err;
  logic [1:0] e_ready, e_valid;
  int         w;

  function automatic int model_win(input logic [1:0] v, input int last);
    if (v == 2'b11) begin
`ifdef ALU_ARB_FIXED_PRIO_EN
      return 0;
`else
      return (last == 1) ? 0 : 1;
`endif
    end
    return v[1] ? 1 : 0;
  endfunction

  always @(negedge clk) begin
    if (m_ok) begin
      e_ready = 2'b00;
      if (!rst && !m_busy && req_valid != 2'b00) e_ready = 2'b01 << model_win(req_valid, m_last);
      e_valid = (m_busy && m_age >= 2) ? (2'b01 << m_g) : 2'b00;
      chk("m_req_ready", req_ready, e_ready);
      chk("m_rsp_valid", rsp_valid, e_valid);
      chk("m_rsp_data",  rsp_data,  m_data);
      chk("m_rsp_err",   rsp_err,   m_err);
      chk("m_alu_a",     alu_a,     m_a);
      chk("m_alu_b",     alu_b,     m_b);
      chk("m_alu_op",    alu_op,    m_op);
    end
    // Advance the model across the coming rising edge (inputs are stable until then).
    if (rst) begin
      m_ok = 1'b1; m_busy = 1'b0; m_age = 0; m_g = 0; m_last = 1;
      m_a = '0; m_b = '0; m_op = '0; m_data = '0; m_err = 1'b0;
    end else if (m_ok) begin
      if (!m_busy) begin
        if (req_valid != 2'b00) begin
          w      = model_win(req_valid, m_last);
          m_busy = 1'b1;
          m_age  = 1;
          m_g    = w;
          m_last = w;
          m_a    = (w == 1) ? a1 : a0;
          m_b    = (w == 1) ? b1 : b0;
          m_op   = (w == 1) ? op1 : op0;
          m_err  = (m_op > 4'd8);
        end
      end else if (m_age == 1) begin
        m_data = ref_alu(m_a, m_b, m_op);
        m_age  = 2;
      end else if (rsp_ready[m_g]) begin
        m_busy = 1'b0;
      end
    end
  end

  // ---------------- directed and random stimulus ----------------
  task automatic step;
    @(posedge clk);
    #1;
  endtask

  task automatic wait_rsp(input logic [1:0] mask, input string name);
    bit found;
    found = 1'b0;
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      if (rsp_valid == mask) begin
        found = 1'b1;
        break;
      end
    end
    if (!found) begin
      checks++;
      failures++;
      $display("FAIL %s: rsp_valid %b never appeared within 12 cycles (last %b)", name, mask, rsp_valid);
    end
  endtask

  int grants[$];

  initial begin
    rst = 1'b1; req_valid = 2'b00; rsp_ready = 2'b11;
    a0 = '0; b0 = '0; op0 = '0; a1 = '0; b1 = '0; op1 = '0;
    step; step;
    @(negedge clk);
    chk("rst_req_ready", req_ready, 2'b00);
    chk("rst_rsp_valid", rsp_valid, 2'b00);
    chk("rst_rsp_data",  rsp_data,  8'd0);
    chk("rst_alu_a",     alu_a,     8'd0);

    // Client 0 alone: 200 + 100 truncates to 44.
    step; rst = 1'b0; req_valid = 2'b01; a0 = 8'd200; b0 = 8'd100; op0 = 4'b0000;
    @(negedge clk);
    chk("t1_req_ready", req_ready, 2'b01);
    step; req_valid = 2'b00;
    @(negedge clk);
    chk("t1_exec_no_valid", rsp_valid, 2'b00);
    @(negedge clk);
    chk("t1_rsp_valid", rsp_valid, 2'b01);
    chk("t1_rsp_data",  rsp_data,  8'd44);
    chk("t1_rsp_err",   rsp_err,   1'b0);
    step; step;

    // Continuous contention from a fresh reset.
    rst = 1'b1; step; rst = 1'b0;
    req_valid = 2'b11; a0 = 8'd10; b0 = 8'd3; op0 = 4'b0001; a1 = 8'd5; b1 = 8'd5; op1 = 4'b1000;
    for (int i = 0; i < 40 && grants.size() < 4; i++) begin
      @(negedge clk);
      if (req_ready != 2'b00) grants.push_back(req_ready[1] ? 1 : 0);
      if (rsp_valid[0]) chk("t2_rsp0_data", rsp_data, 8'd7);
      if (rsp_valid[1]) chk("t2_rsp1_data", rsp_data, 8'd1);
    end
    if (grants.size() < 4) begin
      checks++; failures++;
      $display("FAIL t2_grants: only %0d grants seen, required 4", grants.size());
    end else begin
`ifdef ALU_ARB_FIXED_PRIO_EN
      for (int i = 0; i < 4; i++) chk("t2_grant_fixed", grants[i], 0);
`else
      chk("t2_grant0", grants[0], 0);
      chk("t2_grant1", grants[1], 1);
      chk("t2_grant2", grants[2], 0);
      chk("t2_grant3", grants[3], 1);
`endif
    end
    step; req_valid = 2'b00;
    repeat (4) step;

    // Unsupported opcode from client 1.
    req_valid = 2'b10; a1 = 8'd1; b1 = 8'd2; op1 = 4'b1111;
    wait_rsp(2'b10, "t3_wait");
    chk("t3_rsp_data", rsp_data, 8'd0);
    chk("t3_rsp_err",  rsp_err,  1'b1);
    step; req_valid = 2'b00;
    step;

    // Response backpressure while client 1 is waiting.
    rsp_ready = 2'b10; req_valid = 2'b01; a0 = 8'hF0; b0 = 8'd4; op0 = 4'b0100;
    wait_rsp(2'b01, "t4_wait");
    step; req_valid = 2'b10; a1 = 8'd3; b1 = 8'd4; op1 = 4'b0000;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk("t4_hold_valid", rsp_valid, 2'b01);
      chk("t4_hold_data",  rsp_data,  8'h0F);
      chk("t4_hold_ready", req_ready, 2'b00);
      step;
    end
    rsp_ready = 2'b11;
    wait_rsp(2'b10, "t4_c1_wait");
    chk("t4_c1_data", rsp_data, 8'd7);
    step; req_valid = 2'b00;
    step;

    // Reset during EXEC abandons the transaction.
    req_valid = 2'b01; a0 = 8'd7; b0 = 8'd9; op0 = 4'b0010;
    @(negedge clk);
    chk("t5_req_ready", req_ready, 2'b01);
    step; req_valid = 2'b00; rst = 1'b1;
    step; rst = 1'b0;
    @(negedge clk);
    chk("t5_rsp_valid", rsp_valid, 2'b00);
    chk("t5_rsp_data",  rsp_data,  8'd0);
    chk("t5_rsp_err",   rsp_err,   1'b0);
    chk("t5_alu_a",     alu_a,     8'd0);
    chk("t5_alu_b",     alu_b,     8'd0);
    chk("t5_alu_op",    alu_op,    4'd0);
    for (int i = 0; i < 6; i++) begin
      step;
      @(negedge clk);
      chk("t5_no_rsp", rsp_valid, 2'b00);
    end
    step; req_valid = 2'b11; op0 = 4'b0000; op1 = 4'b0000;
    @(negedge clk);
    chk("t5_tie_after_rst", req_ready, 2'b01);
    step; req_valid = 2'b00;
    repeat (4) step;

    // Randomized traffic, backpressure and occasional resets.
    for (int i = 0; i < 3000; i++) begin
      req_valid = 2'($urandom_range(0, 3));
      rsp_ready = 2'($urandom_range(0, 3));
      a0 = 8'($urandom); b0 = 8'($urandom); op0 = 4'($urandom);
      a1 = 8'($urandom); b1 = 8'($urandom); op1 = 4'($urandom);
      rst = ($urandom_range(0, 99) == 0);
      step;
    end
    rst = 1'b0; req_valid = 2'b00; rsp_ready = 2'b11;
    repeat (4) step;

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/alu_arbiter.md
# alu_arbiter

Two-requester arbiter and sequencer for the shared 8-bit ALU. It accepts operation requests (A, B, op) from two independent clients over valid/ready handshakes and grants one per transaction. It drives the granted operands into the combinational ALU, registers the result, and returns it to the originating client over a per-client response handshake. It sits between the client blocks and the single ALU instance, so the ALU never sees contention.

## Interface
- `WIDTH`, 8: operand and result width; must match the ALU.
- `OPW`, 4: opcode width.
- `clk`  in  1: sole clock, rising edge.
- `rst`  in  1: synchronous, active-high reset.
- `req_valid`  in  2: per-client request valid; bit i belongs to client i.
- `req_ready`  out  2: per-client accept strobe.
- `req_A0`, `req_B0`  in  WIDTH: client 0 operands.
- `req_op0`  in  OPW: client 0 opcode.
- `req_A1`, `req_B1`  in  WIDTH: client 1 operands.
- `req_op1`  in  OPW: client 1 opcode.
- `rsp_valid`  out  2: per-client response valid.
- `rsp_ready`  in  2: per-client response accept.
- `rsp_data`  out  WIDTH: registered ALU result, shared by both clients.
- `rsp_err`  out  1: the opcode was above 4'b1000 (unsupported; the ALU returns 0).
- `alu_A`, `alu_B`  out  WIDTH: operands to the ALU.
- `alu_op`  out  OPW: opcode to the ALU.
- `alu_out`  in  WIDTH: combinational ALU result.

## Operation
- The FSM has three states: IDLE, EXEC and RESP.
- **IDLE**
  - If any `req_valid` bit is set, pick a winner `g` and assert `req_ready[g]` combinationally in that cycle.
  - On the edge: latch A, B and op of client `g` into operand registers, latch `g`, compute `err = (op > 4'b1000)`, and go to EXEC.
  - The losing client sees `req_ready` = 0 and must hold its request.
- **EXEC**
  - `alu_A`, `alu_B` and `alu_op` are driven from the operand registers.
  - On the edge: `rsp_data <= alu_out` and go to RESP.
- **RESP**
  - `rsp_valid[g]` = 1, with `rsp_data` and `rsp_err` stable.
  - On `rsp_ready[g]` = 1: drop `rsp_valid` and go to IDLE. Otherwise hold indefinitely.
  - `rsp_ready` of the non-granted client is ignored.
- **Arbitration (default)**
  - Round-robin on a `last` pointer: when both clients request, the one not served most recently wins.
  - `last` updates only on accept.
  - After reset `last` = 1, so client 0 wins the first tie.
- **ALU port outside EXEC**
  - `alu_*` hold the last latched operands; there is no glitching to other clients' inputs.
- `req_ready` is 0 in every state except IDLE.
- At most one transaction is in flight. A new request is not accepted in the cycle the response completes.
- Widths: the result is truncated to WIDTH by the ALU (e.g. 200+100 → 44). The arbiter does not extend or sign-convert.

## Timing
- Reset (synchronous) sets:
  - state = IDLE, `last` = 1;
  - operand registers, `rsp_data` and `rsp_err` = 0;
  - `rsp_valid` = 2'b00 and `req_ready` = 2'b00 (the latter while `rst` is high).
- Latency: accept at edge N, `rsp_valid` high from cycle N+2. Minimum 3 cycles per transaction (accept, exec, response handshake).
- Back-to-back transactions: the next accept occurs no earlier than the cycle after the `rsp_ready` edge.
- Simultaneous requests: exactly one `req_ready` bit may be high at a time.
- A request deasserted before acceptance is simply not served; the arbiter holds no memory of it.
- Reset mid-transaction (EXEC or RESP): the transaction is abandoned, no response is issued, and the FSM is in IDLE on the next cycle.

## Configuration
- `ALU_ARB_FIXED_PRIO_EN`
  - **Defined:** client 0 always wins when both request; the `last` pointer is removed.
  - **Undefined (default):** round-robin as described above.
  - Handshakes and latency are identical in both builds.

## Test plan
- Client 0 alone sends A=200, B=100, op=4'b0000.
  - Required: `req_ready[0]` in the request cycle, `rsp_valid[0]` two cycles later, `rsp_data` = 44, `rsp_err` = 0.
- Both clients request continuously: client 0 with op=4'b0001, A=10, B=3; client 1 with op=4'b1000, A=5, B=5; `rsp_ready` tied high.
  - Required: grants alternate 0,1,0,1; responses are 7 and 1 respectively.
- Client 1 sends op=4'b1111.
  - Required: `rsp_data` = 0, `rsp_err` = 1.
- Client 0 sends A=8'hF0, B=4, op=4'b0100, and its `rsp_ready` is held low for 5 cycles.
  - Required: `rsp_valid[0]` and `rsp_data` = 8'h0F are stable for all 5 cycles, and no `req_ready` is asserted during them.
- Assert `rst` during EXEC.
  - Required: no `rsp_valid` ever; all outputs are 0 on the following cycle; the next request is accepted normally and client 0 wins a tie.
- With `ALU_ARB_FIXED_PRIO_EN` defined, both clients request continuously.
  - Required: client 0 is granted every time; client 1 is never granted.
